// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline register chain.
// Stage state is encoded as {m_valid, s_valid} so the valid bits fall
// straight out of the state register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,  // nothing held
    ST_BUSY  = 2'b10,  // main holds a word, skid free
    ST_FULL  = 2'b11   // main and skid both hold words
  } stage_state_e;

  // Default bubble word loaded on reset/flush (all-zero NOP).
  localparam logic [63:0] BUBBLE_NOP = 64'h0;

endpackage

// File: rtl/pipe_skid_stage.sv
// One valid/ready pipeline stage with a main register and a skid slot.
// in_ready depends only on registered state, so it never combines with
// out_ready. Flush handling is built only with PIPE_SKID_REG_FLUSH_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             acc, drn;

`ifdef PIPE_SKID_REG_FLUSH_EN
  assign in_ready  = (state_q != ST_FULL) & ~flush;
  assign out_valid = (state_q != ST_EMPTY) & ~flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
`endif

  assign out_data = m_data_q;
  assign acc      = in_valid & in_ready;
  assign drn      = out_valid & out_ready;

  // Next state and data: registers load only on their own transfer.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d  = ST_BUSY;
          m_data_d = in_data;
        end
      end
      ST_BUSY: begin
        if (acc && drn) begin
          m_data_d = in_data;
        end else if (acc) begin
          state_d  = ST_FULL;
          s_data_d = in_data;
        end else if (drn) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drn) begin
          state_d  = ST_BUSY;
          m_data_d = s_data_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
`ifdef PIPE_SKID_REG_FLUSH_EN
    if (flush) begin
      state_d  = ST_EMPTY;
      m_data_d = BUBBLE;
      s_data_d = BUBBLE;
    end
`endif
  end

  // State and data registers; reset empties the stage and loads the bubble.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= ST_EMPTY;
      m_data_q <= BUBBLE;
      s_data_q <= BUBBLE;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Configurable-width, configurable-depth skid-buffered pipeline register.
// Chains DEPTH pipe_skid_stage instances and keeps a registered count of
// words held. Optional synchronous flush: define PIPE_SKID_REG_FLUSH_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = BUBBLE_NOP[WIDTH-1:0]
) (
  input  logic                             clk,
  input  logic                             clrn,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             flush,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  // Link k carries stage k-1 output into stage k; link 0/DEPTH are the ports.
  logic [DEPTH:0][WIDTH-1:0] lnk_data;
  logic [DEPTH:0]            lnk_valid;
  logic [DEPTH:0]            lnk_ready;

  assign lnk_data[0]      = in_data;
  assign lnk_valid[0]     = in_valid;
  assign in_ready         = lnk_ready[0];
  assign out_data         = lnk_data[DEPTH];
  assign out_valid        = lnk_valid[DEPTH];
  assign lnk_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_skid_stage #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
    ) u_stage (
      .clk       (clk),
      .clrn      (clrn),
      .in_data   (lnk_data[k]),
      .in_valid  (lnk_valid[k]),
      .in_ready  (lnk_ready[k]),
      .out_data  (lnk_data[k+1]),
      .out_valid (lnk_valid[k+1]),
      .out_ready (lnk_ready[k+1]),
      .flush     (flush)
    );
  end

  // Internal stage-to-stage moves conserve the word count, so occupancy
  // only changes on chain-level accept/drain.
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             up, dn;

  assign up        = in_valid & in_ready;
  assign dn        = out_valid & out_ready;
  assign occupancy = occ_q;

  // Occupancy next value: +1 on accept only, -1 on drain only.
  always_comb begin
    occ_d = occ_q;
    if (up && !dn)      occ_d = occ_q + OCC_W'(1);
    else if (dn && !up) occ_d = occ_q - OCC_W'(1);
`ifdef PIPE_SKID_REG_FLUSH_EN
    if (flush) occ_d = '0;
`endif
  end

  // Occupancy register, updated on the same edge as the stage valids.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) occ_q <= '0;
    else       occ_q <= occ_d;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: DUT A (DEPTH=3) and DUT B (DEPTH=2).
// Scoreboard queues collect words on input transfers and check them on
// output transfers; a table drives the DEPTH=2 backpressure sequence.
module tb_pipe_skid_reg;

  localparam int          W   = 32;
  localparam logic [W-1:0] BUB = 32'h0000_0013;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic [W-1:0] a_in_data, a_out_data, b_in_data, b_out_data;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [2:0]   a_occ, b_occ;

  pipe_skid_reg #(.WIDTH(W), .DEPTH(3), .BUBBLE(BUB)) u_a (
    .clk(clk), .clrn(clrn),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .flush(a_flush), .occupancy(a_occ)
  );

  pipe_skid_reg #(.WIDTH(W), .DEPTH(2), .BUBBLE(BUB)) u_b (
    .clk(clk), .clrn(clrn),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .flush(b_flush), .occupancy(b_occ)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and occupancy model, sampled mid-cycle (inputs change only
  // just after posedge, so negedge sees exactly what the next edge will see).
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int occ_a = 0;
  int occ_b = 0;

  always @(negedge clk) begin
    if (!clrn) begin
      qa.delete(); qb.delete();
      occ_a = 0; occ_b = 0;
    end else begin
      chk("a_occupancy", 64'(a_occ), 64'(occ_a));
      chk("b_occupancy", 64'(b_occ), 64'(occ_b));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_output", 64'(1), 64'(0));
        else chk("a_out_data", 64'(a_out_data), 64'(qa.pop_front()));
        occ_a--;
      end
      if (a_in_valid && a_in_ready) begin
        qa.push_back(a_in_data);
        occ_a++;
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_output", 64'(1), 64'(0));
        else chk("b_out_data", 64'(b_out_data), 64'(qb.pop_front()));
        occ_b--;
      end
      if (b_in_valid && b_in_ready) begin
        qb.push_back(b_in_data);
        occ_b++;
      end
`ifdef PIPE_SKID_REG_FLUSH_EN
      if (a_flush) begin qa.delete(); occ_a = 0; end
      if (b_flush) begin qb.delete(); occ_b = 0; end
`endif
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_in_ready"},  64'(a_in_ready),  64'(1));
    chk({tag, "_a_out_valid"}, 64'(a_out_valid), 64'(0));
    chk({tag, "_a_out_data"},  64'(a_out_data),  64'(BUB));
    chk({tag, "_a_occ"},       64'(a_occ),       64'(0));
    chk({tag, "_b_in_ready"},  64'(b_in_ready),  64'(1));
    chk({tag, "_b_out_valid"}, 64'(b_out_valid), 64'(0));
    chk({tag, "_b_out_data"},  64'(b_out_data),  64'(BUB));
    chk({tag, "_b_occ"},       64'(b_occ),       64'(0));
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
  endtask

  // Drain both chains with a bounded cycle budget.
  task automatic drain_all(input string tag);
    int n;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    n = 0;
    while ((a_occ != 0 || b_occ != 0) && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_drain_timeout"}, 64'(n < 40), 64'(1));
    step();
    chk({tag, "_qa_empty"}, 64'(qa.size()), 64'(0));
    chk({tag, "_qb_empty"}, 64'(qb.size()), 64'(0));
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic [2:0]   exp_occ;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // DEPTH=2 backpressure: 4 words absorbed, then drained in order.
    tbl[0] = '{1'b1, 32'h101, 1'b0, 1'b1, 1'b0, 3'd1};
    tbl[1] = '{1'b1, 32'h102, 1'b0, 1'b1, 1'b1, 3'd2};
    tbl[2] = '{1'b1, 32'h103, 1'b0, 1'b1, 1'b1, 3'd3};
    tbl[3] = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 3'd4};
    tbl[4] = '{1'b1, 32'h105, 1'b0, 1'b0, 1'b1, 3'd4};
    tbl[5] = '{1'b1, 32'h105, 1'b0, 1'b0, 1'b1, 3'd4};
    tbl[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 3'd3};
    tbl[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd2};
    tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 3'd1};
    tbl[9] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 3'd0};

    // ---- reset with busy inputs ----
    clrn = 1'b0;
    a_in_data = '0; b_in_data = '0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_out_ready = 1'b1; a_flush = 1'b1; a_in_data = $urandom;
      b_in_valid = 1'b1; b_out_ready = 1'b1; b_flush = 1'b1; b_in_data = $urandom;
      step();
    end
    chk_reset_vals("rst_held");
    idle_inputs();
    #2 clrn = 1'b1;
    step();
    chk_reset_vals("rst_rel");

    // ---- streaming, DEPTH=3, 0x1..0xA ----
    a_out_ready = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      if (j <= 10) begin a_in_valid = 1'b1; a_in_data = 32'(j); end
      else a_in_valid = 1'b0;
      step();
      chk("stream_in_ready", 64'(a_in_ready), 64'(1));
      chk("stream_out_valid", 64'(a_out_valid), 64'(j >= 3 && j <= 12));
      if (j >= 3 && j <= 12) chk("stream_out_data", 64'(a_out_data), 64'(j - 2));
      chk("stream_occ", 64'(a_occ), 64'((j <= 2) ? j : (j <= 10) ? 3 : 13 - j));
    end
    a_out_ready = 1'b0;

    // ---- backpressure table, DEPTH=2 ----
    for (int i = 0; i < 10; i++) begin
      b_in_valid = tbl[i].iv; b_in_data = tbl[i].d; b_out_ready = tbl[i].ordy;
      step();
      chk($sformatf("bp%0d_in_ready", i),  64'(b_in_ready),  64'(tbl[i].exp_ir));
      chk($sformatf("bp%0d_out_valid", i), 64'(b_out_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("bp%0d_occ", i),       64'(b_occ),       64'(tbl[i].exp_occ));
    end
    b_out_ready = 1'b0;

    // ---- flush with occupancy 3 on DEPTH=3 ----
    for (int j = 1; j <= 3; j++) begin
      a_in_valid = 1'b1; a_in_data = 32'h200 + 32'(j);
      step();
    end
    chk("fl_pre_occ", 64'(a_occ), 64'(3));
    a_in_data = 32'h2FF; a_flush = 1'b1;
`ifdef PIPE_SKID_REG_FLUSH_EN
    #1 chk("fl_in_ready_gated", 64'(a_in_ready), 64'(0));
    chk("fl_out_valid_gated", 64'(a_out_valid), 64'(0));
`endif
    step();
    a_flush = 1'b0;
`ifdef PIPE_SKID_REG_FLUSH_EN
    chk("fl_occ", 64'(a_occ), 64'(0));
    chk("fl_out_valid", 64'(a_out_valid), 64'(0));
    chk("fl_out_data", 64'(a_out_data), 64'(BUB));
`else
    chk("fl_occ", 64'(a_occ), 64'(4));
    chk("fl_out_valid", 64'(a_out_valid), 64'(1));
    chk("fl_out_data", 64'(a_out_data), 64'(32'h201));
`endif
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h204;
    step();
    a_in_valid = 1'b0;
    step();
    step();
`ifdef PIPE_SKID_REG_FLUSH_EN
    chk("fl_resume_valid", 64'(a_out_valid), 64'(1));
    chk("fl_resume_data", 64'(a_out_data), 64'(32'h204));
`endif
    drain_all("post_flush");

    // ---- async reset mid-stream, DEPTH=2 with occupancy 4 ----
    idle_inputs();
    for (int j = 0; j < 5; j++) begin
      b_in_valid = 1'b1; b_in_data = 32'h300 + 32'(j);
      step();
    end
    chk("ar_pre_occ", 64'(b_occ), 64'(4));
    #1 clrn = 1'b0;
    #1 chk_reset_vals("ar_async");
    idle_inputs();
    @(negedge clk);
    #2 clrn = 1'b1;
    step();
    chk_reset_vals("ar_rel");

    // ---- random stall ----
    for (int c = 0; c < 10000; c++) begin
      a_in_valid = 1'($urandom_range(0, 1)); a_out_ready = 1'($urandom_range(0, 1));
      a_in_data = $urandom;
      b_in_valid = 1'($urandom_range(0, 1)); b_out_ready = 1'($urandom_range(0, 1));
      b_in_data = $urandom;
      step();
    end
    drain_all("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
